// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative 33-cycle multiply/divide unit with HI/LO registers.
//            Divide support is compiled in only when MDU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_signed_op;
    logic               w_op_ok;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_fixed;

    assign w_signed_op = ~op[0];
    assign w_abs_a     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_abs_b     = (w_signed_op && b[WIDTH-1]) ? -b : b;

`ifdef MDU_DIV_EN
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_quo_fixed;
    logic [WIDTH-1:0]   w_rem_fixed;

    assign w_op_ok     = 1'b1;
    // 33-bit partial remainder: previous remainder with the next dividend bit shifted in
    assign w_div_shift = {rem_q, acc_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, mcand_q};
    assign w_quo_fixed = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem_fixed = sign_a_q ? -rem_q : rem_q;
`else
    assign w_op_ok     = ~op[1];
`endif

    assign w_accept     = start && w_op_ok && ((state_q == S_IDLE) || (state_q == S_DONE));
    // Upper accumulator half plus optional multiplicand, with carry kept for the shift
    assign w_mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign w_prod_fixed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MDU_DIV_EN
        is_div_d = is_div_q;
        rem_d    = rem_q;
`endif

        if (!busy_q) begin
            if (wr_hi) hi_d = wr_data;
            if (wr_lo) lo_d = wr_data;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    sign_a_d = w_signed_op & a[WIDTH-1];
                    sign_b_d = w_signed_op & b[WIDTH-1];
`ifdef MDU_DIV_EN
                    is_div_d = op[1];
                    rem_d    = '0;
                    // Divide: mcand holds the divisor, acc low half shifts dividend out / quotient in
                    mcand_d  = op[1] ? w_abs_b : w_abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
`else
                    mcand_d  = w_abs_a;
                    acc_d    = {{WIDTH{1'b0}}, w_abs_b};
`endif
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    rem_d = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
                end else begin
                    acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
                end
`else
                acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
`endif
            end

            S_FIX: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    hi_d = w_rem_fixed;
                    // Divide by zero reports an all-ones quotient regardless of signs
                    lo_d = (mcand_q == '0) ? {WIDTH{1'b1}} : w_quo_fixed;
                end else begin
                    hi_d = w_prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fixed[WIDTH-1:0];
                end
`else
                hi_d = w_prod_fixed[2*WIDTH-1:WIDTH];
                lo_d = w_prod_fixed[WIDTH-1:0];
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_DIV_EN
            is_div_q <= is_div_d;
            rem_q    <= rem_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit (MDU_DIV_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        a     = 32'h0BAD_0BAD;
        b     = 32'h0BAD_0BAD;
    endtask

    // Edges until done is seen (1-based); -1 if it never appears within the budget
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b required 0/0", busy, done);
        end
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
        end
    endtask

    task automatic test_multu_max();
        int busy_cycles;
        int lat;
        do_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_cycles = busy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL multu_latency: got %0d edges required 33", lat);
        end
        n_checks++;
        if (busy_cycles !== 33) begin
            n_fail++;
            $display("FAIL multu_busy_cycles: got %0d required 33", busy_cycles);
        end
        n_checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_result: hi=%h lo=%h required fffffffe/00000001", hi, lo);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL multu_done_pulse: done=%b busy=%b required 0/0", done, busy);
        end
        n_checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_hold: hi=%h lo=%h required fffffffe/00000001", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_start(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mult_neg: lat=%0d hi=%h lo=%h required 33/ffffffff/fffffff1", lat, hi, lo);
        end
        do_start(OP_MULT, 32'd7, 32'd6);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b required 1/0", busy, done);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b_mult: lat=%0d hi=%h lo=%h required 33/0/2a", lat, hi, lo);
        end
    endtask

    task automatic test_write_with_start();
        int lat;
        wr_lo   = 1'b1;
        wr_data = 32'h0000_AAAA;
        do_start(OP_MULTU, 32'd2, 32'd3);
        wr_lo   = 1'b0;
        n_checks++;
        if (lo !== 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL start_write: lo=%h required 0000aaaa", lo);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'd6) begin
            n_fail++;
            $display("FAIL start_write_overwrite: lat=%0d hi=%h lo=%h required 33/0/6", lat, hi, lo);
        end
    endtask

    task automatic test_ignore_while_busy();
        int lat;
        tick();
        wr_hi   = 1'b1;
        wr_data = 32'h0000_5555;
        tick();
        wr_hi   = 1'b0;
        n_checks++;
        if (hi !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL idle_wr_hi: hi=%h required 00005555", hi);
        end
        do_start(OP_MULTU, 32'd3, 32'd4);
        for (int k = 1; k <= 4; k++) tick();
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start   = 1'b0;
        wr_hi   = 1'b1;
        wr_data = 32'h0000_DEAD;
        tick();
        wr_hi   = 1'b0;
        n_checks++;
        if (hi !== 32'h0000_5555 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_wr_hi: hi=%h busy=%b required 00005555/1", hi, busy);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 27 || hi !== 32'h0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL ignore_result: lat=%0d hi=%h lo=%h required 27/0/c", lat, hi, lo);
        end
        tick();
        wr_lo   = 1'b1;
        wr_data = 32'h0000_1234;
        tick();
        wr_lo   = 1'b0;
        n_checks++;
        if (lo !== 32'h0000_1234 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_wr_lo: hi=%h lo=%h required 0/00001234", hi, lo);
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_divide();
        int lat;
        do_start(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg: lat=%0d hi=%h lo=%h required 33/ffffffff/fffffffd", lat, hi, lo);
        end
        do_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: lat=%0d hi=%h lo=%h required 33/0/80000000", lat, hi, lo);
        end
        do_start(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++;
            $display("FAIL divu_basic: lat=%0d hi=%h lo=%h required 33/2/e", lat, hi, lo);
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        do_start(OP_DIVU, 32'd100, 32'd0);
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_zero: lat=%0d hi=%h lo=%h required 33/64/ffffffff", lat, hi, lo);
        end
        do_start(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_done(lat);
        n_checks++;
        if (lat !== 33 || hi !== 32'hFFFF_FFFB || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_zero: lat=%0d hi=%h lo=%h required 33/fffffffb/ffffffff", lat, hi, lo);
        end
    endtask
`else
    task automatic test_div_disabled();
        logic seen;
        tick();
        wr_hi   = 1'b1;
        wr_lo   = 1'b1;
        wr_data = 32'h0000_0077;
        tick();
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        start   = 1'b1;
        op      = OP_DIVU;
        a       = 32'd100;
        b       = 32'd7;
        tick();
        start   = 1'b0;
        op      = OP_DIV;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_disabled_busy: busy=%b required 0", busy);
        end
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy || done) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL div_disabled_activity: busy/done seen=%b required 0", seen);
        end
        n_checks++;
        if (hi !== 32'h77 || lo !== 32'h77) begin
            n_fail++;
            $display("FAIL div_disabled_hilo: hi=%h lo=%h required 77/77", hi, lo);
        end
    endtask
`endif

    task automatic test_reset_abort();
        logic seen;
        do_start(OP_MULTU, 32'd5, 32'd5);
        for (int k = 1; k <= 9; k++) tick();
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
        end
        tick();
        #3;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_no_done: seen=%b hi=%h lo=%h required 0/0/0", seen, hi, lo);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = OP_MULT;
        a        = 32'h0;
        b        = 32'h0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        wr_data  = 32'h0;
        tick();
        tick();
        test_reset();
        #3;
        reset_n = 1'b1;
        tick();
        test_multu_max();
        test_back_to_back();
        test_write_with_start();
        test_ignore_while_busy();
`ifdef MDU_DIV_EN
        test_divide();
        test_div_by_zero();
`else
        test_div_disabled();
`endif
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
